// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode stage with a single output register.
//
// Decodes one 32-bit instruction per cycle into control bits, ALU operation,
// a sign-extended immediate and register fields. The result is registered, so
// an instruction accepted at one edge is visible after that edge. A load-use
// interlock inserts a bubble when the instruction in the output register is a
// load whose destination is read by the incoming instruction.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_instr/in_pc  instruction from fetch; in_ready accepts it
//   stall                downstream cannot accept; output register holds
//   flush                squash the output register and drop the input
//   out_*                registered decode results; out_ctrl is zero when !out_valid
//   hazard               combinational load-use stall indication
module decode_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ILEN = 32  // only 32 is supported
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [ILEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            in_ready,
    input  logic            stall,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [9:0]      out_ctrl,
    output logic [3:0]      out_aluctl,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_illegal,
    output logic            hazard
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    // Bit positions inside the control vector.
    localparam int unsigned CRegWrite = 9;
    localparam int unsigned CMemRead  = 8;
    localparam int unsigned CMemWrite = 7;
    localparam int unsigned CMemToReg = 6;
    localparam int unsigned CAluSrc   = 5;
    localparam int unsigned CBranch   = 4;
    localparam int unsigned CJal      = 3;
    localparam int unsigned CJalr     = 2;
    localparam int unsigned CLui      = 1;
    localparam int unsigned CAuipc    = 0;

    localparam logic [3:0] AluAnd  = 4'd0;
    localparam logic [3:0] AluOr   = 4'd1;
    localparam logic [3:0] AluAdd  = 4'd2;
    localparam logic [3:0] AluXor  = 4'd3;
    localparam logic [3:0] AluSll  = 4'd4;
    localparam logic [3:0] AluSrl  = 4'd5;
    localparam logic [3:0] AluSub  = 4'd6;
    localparam logic [3:0] AluSltu = 4'd7;
    localparam logic [3:0] AluSra  = 4'd8;
    localparam logic [3:0] AluSlt  = 4'd9;
    localparam logic [3:0] AluPass = 4'd15;

    // funct3 to ALU op; alt selects sub/sra.
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm32;
    logic [9:0]  w_ctrl;
    logic [3:0]  w_aluctl;
    logic        w_illegal;
    logic        w_use_rs1;
    logic        w_use_rs2;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_imm;
    logic [9:0]      r_ctrl;
    logic [3:0]      r_aluctl;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic            r_illegal;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];
    assign w_rs1    = in_instr[19:15];
    assign w_rs2    = in_instr[24:20];
    assign w_rd     = in_instr[11:7];

    assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                      in_instr[11:8], 1'b0};
    assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                      in_instr[30:21], 1'b0};
    assign w_imm_u = {in_instr[31:12], 12'b0};

    always_comb begin
        w_ctrl    = '0;
        w_imm32   = '0;
        w_aluctl  = AluPass;
        w_illegal = 1'b0;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b0;
        case (w_opcode)
            OpLoad: begin
                w_ctrl[CRegWrite] = 1'b1;
                w_ctrl[CMemRead]  = 1'b1;
                w_ctrl[CMemToReg] = 1'b1;
                w_ctrl[CAluSrc]   = 1'b1;
                w_imm32           = w_imm_i;
                w_aluctl          = AluAdd;
            end
            OpStore: begin
                w_ctrl[CMemWrite] = 1'b1;
                w_ctrl[CAluSrc]   = 1'b1;
                w_imm32           = w_imm_s;
                w_aluctl          = AluAdd;
                w_use_rs2         = 1'b1;
            end
            OpReg: begin
                w_ctrl[CRegWrite] = 1'b1;
                w_aluctl          = alu_op(w_funct3, w_funct7 == 7'b0100000);
                w_use_rs2         = 1'b1;
            end
            OpImm: begin
                w_ctrl[CRegWrite] = 1'b1;
                w_ctrl[CAluSrc]   = 1'b1;
                w_imm32           = w_imm_i;
                // Only shifts honour instr[30]; addi with a negative imm stays add.
                w_aluctl          = alu_op(w_funct3, (w_funct3 == 3'b101) && in_instr[30]);
            end
            OpBranch: begin
                w_ctrl[CBranch] = 1'b1;
                w_imm32         = w_imm_b;
                w_use_rs2       = 1'b1;
                case (w_funct3[2:1])
                    2'b10:   w_aluctl = AluSlt;
                    2'b11:   w_aluctl = AluSltu;
                    default: w_aluctl = AluSub;
                endcase
            end
            OpJal: begin
                w_ctrl[CRegWrite] = 1'b1;
                w_ctrl[CJal]      = 1'b1;
                w_imm32           = w_imm_j;
                w_use_rs1         = 1'b0;
            end
            OpJalr: begin
                w_ctrl[CRegWrite] = 1'b1;
                w_ctrl[CAluSrc]   = 1'b1;
                w_ctrl[CJalr]     = 1'b1;
                w_imm32           = w_imm_i;
                w_aluctl          = AluAdd;
            end
            OpLui: begin
                w_ctrl[CRegWrite] = 1'b1;
                w_ctrl[CAluSrc]   = 1'b1;
                w_ctrl[CLui]      = 1'b1;
                w_imm32           = w_imm_u;
                w_use_rs1         = 1'b0;
            end
            OpAuipc: begin
                w_ctrl[CRegWrite] = 1'b1;
                w_ctrl[CAluSrc]   = 1'b1;
                w_ctrl[CAuipc]    = 1'b1;
                w_imm32           = w_imm_u;
                w_aluctl          = AluAdd;
                w_use_rs1         = 1'b0;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Load in the output register whose rd feeds the incoming instruction.
    assign hazard = r_valid && r_ctrl[CMemRead] && (r_rd != 5'd0) && in_valid &&
                    ((w_use_rs1 && (r_rd == w_rs1)) || (w_use_rs2 && (r_rd == w_rs2)));

    assign in_ready = (!stall && !hazard) || flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_imm     <= '0;
            r_ctrl    <= '0;
            r_aluctl  <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (!stall) begin
            if (hazard) begin
                r_valid <= 1'b0;
            end else begin
                r_valid   <= in_valid;
                r_pc      <= in_pc;
                r_imm     <= XLEN'($signed(w_imm32));
                r_ctrl    <= w_ctrl;
                r_aluctl  <= w_aluctl;
                r_rs1     <= w_rs1;
                r_rs2     <= w_rs2;
                r_rd      <= w_rd;
                r_illegal <= w_illegal;
            end
        end
    end

    assign out_valid   = r_valid;
    assign out_pc      = r_pc;
    assign out_imm     = r_imm;
    assign out_ctrl    = r_valid ? r_ctrl : 10'd0;
    assign out_aluctl  = r_aluctl;
    assign out_rs1     = r_rs1;
    assign out_rs2     = r_rs2;
    assign out_rd      = r_rd;
    assign out_illegal = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage.
// Expected decode results are queued as instructions are driven and popped
// when they appear on the registered outputs.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [9:0]  out_ctrl;
    logic [3:0]  out_aluctl;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_illegal;
    logic        hazard;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [9:0]  ctrl;
        logic [9:0]  mask;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    decode_stage #(
        .XLEN(32),
        .ILEN(32)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .in_ready   (in_ready),
        .stall      (stall),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_imm    (out_imm),
        .out_ctrl   (out_ctrl),
        .out_aluctl (out_aluctl),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_rd     (out_rd),
        .out_illegal(out_illegal),
        .hazard     (hazard)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] imm,
                            input logic [9:0] ctrl, input logic [9:0] mask,
                            input logic [3:0] alu, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic ill);
        exp_t e;
        e.pc = pc; e.imm = imm; e.ctrl = ctrl; e.mask = mask;
        e.alu = alu; e.rd = rd; e.rs1 = rs1; e.ill = ill;
        sb.push_back(e);
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [9:0] ctrl, input logic [9:0] mask, input logic [3:0] alu,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic ill);
        drive(1'b1, instr, pc);
        push_exp(pc, imm, ctrl, mask, alu, rd, rs1, ill);
    endtask

    task automatic check_out();
        exp_t e;
        check_eq("out_valid", 32'(out_valid), 32'd1);
        check_eq("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("out_pc", out_pc, e.pc);
            check_eq("out_imm", out_imm, e.imm);
            check_eq("out_ctrl", 32'(out_ctrl & e.mask), 32'(e.ctrl));
            check_eq("out_aluctl", 32'(out_aluctl), 32'(e.alu));
            check_eq("out_rd", 32'(out_rd), 32'(e.rd));
            check_eq("out_rs1", 32'(out_rs1), 32'(e.rs1));
            check_eq("out_illegal", 32'(out_illegal), 32'(e.ill));
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_pc"}, out_pc, 32'd0);
        check_eq({tag, "_imm"}, out_imm, 32'd0);
        check_eq({tag, "_ctrl"}, 32'(out_ctrl), 32'd0);
        check_eq({tag, "_aluctl"}, 32'(out_aluctl), 32'd0);
        check_eq({tag, "_regs"}, 32'({out_rs1, out_rs2, out_rd}), 32'd0);
        check_eq({tag, "_illegal"}, 32'(out_illegal), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        #2;
        check_zero("rst0");
        check_eq("rst0_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst0_hazard", 32'(hazard), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back stream across all immediate formats.
        send(32'hFFC12283, 32'h100, 32'hFFFFFFFC, 10'h360, 10'h3FF, 4'd2, 5'd5, 5'd2, 1'b0);
        tick(); check_out();
        send(32'hFE000CE3, 32'h104, 32'hFFFFFFF8, 10'h010, 10'h3FF, 4'd6, 5'd25, 5'd0, 1'b0);
        tick(); check_out();
        send(32'h0010006F, 32'h108, 32'h00000800, 10'h008, 10'h008, 4'd15, 5'd0, 5'd0, 1'b0);
        tick(); check_out();
        send(32'hFE512E23, 32'h10C, 32'hFFFFFFFC, 10'h0A0, 10'h3FF, 4'd2, 5'd28, 5'd2, 1'b0);
        tick(); check_out();
        send(32'h404183B3, 32'h110, 32'h00000000, 10'h200, 10'h3FF, 4'd6, 5'd7, 5'd3, 1'b0);
        tick(); check_out();
        send(32'h40315093, 32'h114, 32'h00000403, 10'h220, 10'h3FF, 4'd8, 5'd1, 5'd2, 1'b0);
        tick(); check_out();
        send(32'h123450B7, 32'h118, 32'h12345000, 10'h002, 10'h002, 4'd15, 5'd1, 5'd8, 1'b0);
        tick(); check_out();
        send(32'h0000007F, 32'h11C, 32'h00000000, 10'h000, 10'h3FF, 4'd15, 5'd0, 5'd0, 1'b1);
        tick(); check_out();
        drive(1'b0, 32'd0, 32'd0);
        tick();
        check_eq("idle_valid", 32'(out_valid), 32'd0);
        check_eq("idle_ctrl", 32'(out_ctrl), 32'd0);

        // Load-use: lw x5 then add x6,x5,x1 -> one bubble.
        send(32'hFFC12283, 32'h200, 32'hFFFFFFFC, 10'h360, 10'h3FF, 4'd2, 5'd5, 5'd2, 1'b0);
        tick(); check_out();
        drive(1'b1, 32'h00128333, 32'h204);
        push_exp(32'h204, 32'h0, 10'h200, 10'h3FF, 4'd2, 5'd6, 5'd5, 1'b0);
        #1;
        check_eq("lu_hazard", 32'(hazard), 32'd1);
        check_eq("lu_in_ready", 32'(in_ready), 32'd0);
        tick();
        check_eq("bubble_valid", 32'(out_valid), 32'd0);
        check_eq("bubble_ctrl", 32'(out_ctrl), 32'd0);
        check_eq("bubble_hazard", 32'(hazard), 32'd0);
        check_eq("bubble_in_ready", 32'(in_ready), 32'd1);
        tick(); check_out();

        // lw x0 then add x6,x0,x1 -> no interlock.
        send(32'hFFC12003, 32'h300, 32'hFFFFFFFC, 10'h360, 10'h3FF, 4'd2, 5'd0, 5'd2, 1'b0);
        tick(); check_out();
        drive(1'b1, 32'h00100333, 32'h304);
        push_exp(32'h304, 32'h0, 10'h200, 10'h3FF, 4'd2, 5'd6, 5'd0, 1'b0);
        #1;
        check_eq("x0_hazard", 32'(hazard), 32'd0);
        check_eq("x0_in_ready", 32'(in_ready), 32'd1);
        tick(); check_out();

        // Stall holds the output for 3 cycles, then flush wins over stall.
        send(32'hFFC12283, 32'h400, 32'hFFFFFFFC, 10'h360, 10'h3FF, 4'd2, 5'd5, 5'd2, 1'b0);
        tick(); check_out();
        stall = 1'b1;
        drive(1'b1, 32'h00128333, 32'h404);
        #1;
        check_eq("stall_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_pc", out_pc, 32'h400);
            check_eq("stall_imm", out_imm, 32'hFFFFFFFC);
            check_eq("stall_ctrl", 32'(out_ctrl), 32'h360);
        end
        flush = 1'b1;
        #1;
        check_eq("flush_in_ready", 32'(in_ready), 32'd1);
        tick();
        check_eq("flush_valid", 32'(out_valid), 32'd0);
        check_eq("flush_ctrl", 32'(out_ctrl), 32'd0);
        flush = 1'b0;
        stall = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        tick();

        // Illegal opcode, then reset pulsed between edges.
        send(32'h0000007F, 32'h500, 32'h00000000, 10'h000, 10'h3FF, 4'd15, 5'd0, 5'd0, 1'b1);
        tick(); check_out();
        drive(1'b0, 32'd0, 32'd0);
        #3;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        send(32'h123450B7, 32'h600, 32'h12345000, 10'h002, 10'h002, 4'd15, 5'd1, 5'd8, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick(); check_out();
        drive(1'b0, 32'd0, 32'd0);

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter XLEN, default 32, giving the immediate and PC width in bits.
REQ-002 The block SHALL have parameter ILEN, default 32, giving the instruction width in bits; only 32 is supported.

Ports (name, direction, width, meaning):
REQ-003 clk  in  1  the single clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 in_valid  in  1  the fetch stage presents an instruction.
REQ-006 in_instr  in  ILEN  the raw instruction.
REQ-007 in_pc  in  XLEN  the PC of in_instr.
REQ-008 in_ready  out  1  decode accepts in_instr this cycle.
REQ-009 stall  in  1  the downstream (EX) stage cannot accept.
REQ-010 flush  in  1  squash the stage contents (taken branch or jump).
REQ-011 out_valid  out  1  the output register holds a real instruction.
REQ-012 out_pc  out  XLEN  the registered PC.
REQ-013 out_imm  out  XLEN  the registered, sign-extended immediate.
REQ-014 out_ctrl  out  10  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jal, jalr, lui, auipc}, MSB first.
REQ-015 out_aluctl  out  4  the ALU operation code.
REQ-016 out_rs1, out_rs2, out_rd  out  5 each  the register fields.
REQ-017 out_illegal  out  1  the opcode is not recognised.
REQ-018 hazard  out  1  a load-use stall is active (combinational).

Function
REQ-019 Opcodes SHALL be decoded as: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, branch 1100011, jal 1101111, jalr 1100111, lui 0110111, auipc 0010111.
REQ-020 Immediates SHALL use the RV32I I, S, B, J and U formats, with bit 31 sign-extended to XLEN.
- B and J immediates: bit 0 = 0.
- U immediate: instr[31:12] followed by 12 zero bits.
- R-type and unknown opcodes: immediate = 0.
REQ-021 out_aluctl SHALL use these codes:
- and 0, or 1, add 2, xor 3, sll 4, srl 5, sub 6, sltu 7, sra 8, slt 9, pass 15.
- sub and sra are selected by R-type funct7 = 0100000.
- srai is selected by I-type instr[30] = 1.
- Branch funct3 maps: beq/bne to 6, blt/bge to 9, bltu/bgeu to 7.
- lw, sw, jalr, auipc map to 2; jal and lui map to 15.
REQ-022 An unknown opcode SHALL produce out_ctrl = 0, out_imm = 0, out_aluctl = 15 and out_illegal = 1, and SHALL still be passed with out_valid = 1.
REQ-023 Decode latency SHALL be 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
REQ-024 The hazard signal SHALL be asserted when all of the following hold:
- out_valid = 1, out_ctrl.mem_read = 1 and out_rd != 0;
- in_valid = 1;
- out_rd equals in_instr rs1 (for any opcode except jal, lui, auipc), or equals in_instr rs2 (for R, sw and branch only).
REQ-025 in_ready SHALL equal (!stall && !hazard) || flush.
REQ-026 The output register SHALL update with this priority:
- flush: out_valid <= 0 and the input is dropped.
- else stall: all outputs hold.
- else hazard: out_valid <= 0 (bubble) and the input is held upstream.
- else: load the decoded in_instr with out_valid <= in_valid.
REQ-027 While out_valid = 0, out_ctrl SHALL be forced to 0, so a bubble never writes registers or memory.
REQ-028 When flush and stall are both asserted, flush SHALL win.
REQ-029 x0 SHALL never cause a hazard.

Reset
REQ-030 When rst is asserted, all outputs SHALL go to 0 immediately without waiting for a clock edge: out_valid, out_pc, out_imm, out_ctrl, out_aluctl, out_rs*, out_rd, out_illegal.
REQ-031 Reset asserted mid-stall or mid-hazard SHALL discard the held instruction.
REQ-032 The first acceptance after reset SHALL occur on the first rising edge at which rst = 0.

Verification
REQ-033 The bench SHALL cover each of the following scenarios:
- lw x5,-4(x2) (0xFFC12283), pc 0x100 -> next cycle: out_imm 0xFFFFFFFC, mem_read = 1, reg_write = 1, mem_to_reg = 1, alu_src = 1, out_aluctl 2, out_rd 5.
- beq with imm -8 (0xFE000CE3), then jal imm +2048 (0x0010006F) -> out_imm 0xFFFFFFF8 with aluctl 6; then out_imm 0x00000800 with aluctl 15.
- lw x5 followed by add x6,x5,x1 -> hazard = 1 and in_ready = 0 for exactly one cycle; one bubble (out_valid = 0, out_ctrl = 0); then the add with out_rs1 = 5.
- lw x0 followed by add x6,x0,x1 -> no hazard and no bubble.
- stall held high for 3 cycles with a valid output -> outputs unchanged; assert flush during the stall -> out_valid = 0 on the next edge.
- opcode 0x7F -> out_illegal = 1, out_ctrl = 0, out_valid = 1; rst pulsed between edges -> outputs return to 0 immediately.
